// File: rtl/pwm_pkg.sv
// ---------------------------------------------------------------------------
// pwm_pkg
// Shared definitions for the multi-channel PWM block.
//   MODE_EDGE / MODE_CENTER : counting style selected by the mode input
//   dir_t                   : period counter direction
//   duty_w()                : width of one duty slice (R+1 so 100% is reachable)
// ---------------------------------------------------------------------------
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  function automatic int duty_w(input int r);
    return r + 1;
  endfunction

endpackage

// File: rtl/timer_input.sv
// ---------------------------------------------------------------------------
// timer_input
// Free-running prescaler: counts 0..final_value while enabled and flags the
// terminal count, giving one done pulse every final_value+1 clocks.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   enable        : count when 1; counter held at 0 when 0
//   final_value   : terminal count
//   done          : high during the cycle the count equals final_value
// ---------------------------------------------------------------------------
module timer_input #(
  parameter int BITS = 15
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic [BITS-1:0] final_value,
  output logic            done
);

  logic [BITS-1:0] count;

  assign done = enable && (count == final_value);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (!enable || done) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// ---------------------------------------------------------------------------
// pwm_multi
// Multi-channel PWM generator: one shared prescaler and period counter drive
// CH compare/output channels. Duty and top are double-buffered so they only
// take effect at a period boundary.
// Ports:
//   clk, reset_n  : clock, asynchronous active-low reset
//   enable        : run (1) / idle (0)
//   FINAL_VALUE   : prescaler terminal count (tick every FINAL_VALUE+1 clocks)
//   mode          : 0 edge-aligned, 1 center-aligned (sampled while idle)
//   top           : period counter top value
//   duty          : flattened duty bus, channel i at [i*(R+1) +: R+1]
//   polarity      : per-channel output inversion and idle level
//   duty_load     : strobe capturing duty/top into the shadow registers
//   pwm_out       : registered PWM outputs
//   period_tick   : one-clock pulse at each period end
// ---------------------------------------------------------------------------
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CH         = 4,
  parameter int R          = 8,
  parameter int TIMER_BITS = 15
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [TIMER_BITS-1:0] FINAL_VALUE,
  input  logic                  mode,
  input  logic [R-1:0]          top,
  input  logic [CH*(R+1)-1:0]   duty,
  input  logic [CH-1:0]         polarity,
  input  logic                  duty_load,
  output logic [CH-1:0]         pwm_out,
  output logic                  period_tick
);

  localparam int DW = duty_w(R);

  logic         tick;
  logic         mode_a;
  logic [R-1:0] cnt;
  logic [R-1:0] cnt_nxt;
  logic [R-1:0] top_a;
  logic [R-1:0] top_s;
  dir_t         dir;
  dir_t         dir_nxt;
  logic         period_end;

  timer_input #(
    .BITS(TIMER_BITS)
  ) u_prescaler (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .final_value(FINAL_VALUE),
    .done       (tick)
  );

  // Period counter: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt    <= '0;
      dir    <= DIR_UP;
      mode_a <= MODE_EDGE;
    end else if (!enable) begin
      // Idle holds the counter at its start point so a new run begins at 0/up.
      cnt    <= '0;
      dir    <= DIR_UP;
      mode_a <= mode;
    end else if (tick) begin
      cnt <= cnt_nxt;
      dir <= dir_nxt;
    end
  end

  // Period counter: next state
  always_comb begin
    cnt_nxt = cnt;
    dir_nxt = dir;
    if (top_a == '0) begin
      cnt_nxt = '0;
      dir_nxt = DIR_UP;
    end else if (mode_a == MODE_EDGE) begin
      cnt_nxt = (cnt == top_a) ? '0 : cnt + 1'b1;
      dir_nxt = DIR_UP;
    end else if (dir == DIR_UP) begin
      cnt_nxt = cnt + 1'b1;
      // Direction flips as the counter arrives at top, so the down leg
      // starts on the following tick and top is visited only once.
      if (cnt_nxt == top_a) dir_nxt = DIR_DOWN;
    end else begin
      cnt_nxt = cnt - 1'b1;
      if (cnt_nxt == '0) dir_nxt = DIR_UP;
    end
  end

  // Period counter: outputs
  always_comb begin
    period_end = 1'b0;
    if (tick) begin
      if (top_a == '0) begin
        period_end = 1'b1;
      end else if (mode_a == MODE_EDGE) begin
        period_end = (cnt == top_a);
      end else begin
        // Center period ends on the last down step, just before cnt returns to 0.
        period_end = (dir == DIR_DOWN) && (cnt == R'(1));
      end
    end
  end

  assign period_tick = period_end;

  // Top shadow/active registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      top_s <= '1;
      top_a <= '1;
    end else begin
      if (duty_load) top_s <= top;
      // A load landing on the boundary bypasses the shadow so it is not lost.
      if (!enable || period_end) top_a <= duty_load ? top : top_s;
    end
  end

  for (genvar i = 0; i < CH; i++) begin : g_ch
    logic [DW-1:0] duty_in;
    logic [DW-1:0] duty_s;
    logic [DW-1:0] duty_a;
    logic          raw;
    logic          pwm_q;

    assign duty_in = duty[i*DW +: DW];
    assign raw     = duty_a > {1'b0, cnt};

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        duty_s <= '0;
        duty_a <= '0;
        pwm_q  <= 1'b0;
      end else begin
        if (duty_load) duty_s <= duty_in;
        if (!enable || period_end) duty_a <= duty_load ? duty_in : duty_s;
        if (!enable) begin
          pwm_q <= polarity[i];
        end else if (tick) begin
          pwm_q <= raw ^ polarity[i];
        end
      end
    end

    assign pwm_out[i] = pwm_q;
  end

endmodule

// File: tb/tb_pwm_multi.sv
// ---------------------------------------------------------------------------
// tb_pwm_multi
// Scoreboard bench for pwm_multi. The driver configures a run, derives the
// expected pwm_out/period_tick for every cycle of it from closed-form period
// arithmetic and queues them; a monitor on the falling edge pops and checks.
// ---------------------------------------------------------------------------
module tb_pwm_multi;

  localparam int CH = 4;
  localparam int R  = 8;
  localparam int TB = 15;
  localparam int DW = R + 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [TB-1:0]     final_value;
  logic              mode;
  logic [R-1:0]      top;
  logic [CH*DW-1:0]  duty;
  logic [CH-1:0]     polarity;
  logic              duty_load;
  logic [CH-1:0]     pwm_out;
  logic              period_tick;

  always #5 clk = ~clk;

  pwm_multi #(
    .CH(CH), .R(R), .TIMER_BITS(TB)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .FINAL_VALUE(final_value),
    .mode       (mode),
    .top        (top),
    .duty       (duty),
    .polarity   (polarity),
    .duty_load  (duty_load),
    .pwm_out    (pwm_out),
    .period_tick(period_tick)
  );

  typedef struct {
    int          cyc;
    logic [CH-1:0] pwm;
    logic        ptick;
  } exp_t;

  exp_t q[$];
  exp_t e_mon;
  int   cyc    = 0;
  int   errors = 0;
  int   checks = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Mode must stay put while running.
  logic prev_en = 1'b0;
  logic prev_mode = 1'b0;
  always @(posedge clk) begin
    assert (!(enable && prev_en && (mode !== prev_mode)))
      else $error("mode changed while running at cycle %0d", cyc);
    prev_en   <= enable;
    prev_mode <= mode;
  end

  // Monitor
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e_mon = q.pop_front();
      if (e_mon.cyc != cyc) begin
        checks++;
        errors++;
        $display("FAIL stale_entry cyc=%0d entry_cyc=%0d", cyc, e_mon.cyc);
      end else begin
        checks += 2;
        if (pwm_out !== e_mon.pwm) begin
          errors++;
          $display("FAIL pwm_out cyc=%0d got=%b exp=%b", cyc, pwm_out, e_mon.pwm);
        end
        if (period_tick !== e_mon.ptick) begin
          errors++;
          $display("FAIL period_tick cyc=%0d got=%b exp=%b", cyc, period_tick, e_mon.ptick);
        end
      end
    end
  end

  // Reference model: counter value, period end and period index of tick n.
  function automatic int seq_cnt(input int n, input int tp, input bit ctr);
    int j;
    if (tp == 0) return 0;
    if (!ctr) return n % (tp + 1);
    j = n % (2 * tp);
    return (j <= tp) ? j : 2 * tp - j;
  endfunction

  function automatic bit is_end(input int n, input int tp, input bit ctr);
    if (tp == 0) return 1'b1;
    if (!ctr) return (n % (tp + 1)) == tp;
    return (n % (2 * tp)) == (2 * tp - 1);
  endfunction

  function automatic int period_of(input int n, input int tp, input bit ctr);
    if (tp == 0) return n;
    if (!ctr) return n / (tp + 1);
    return n / (2 * tp);
  endfunction

  // Scenario configuration
  int            s_fv, s_top, s_load_at;
  bit            s_mode, s_do_load;
  int            s_duty[CH];
  int            s_new[CH];
  logic [CH-1:0] s_pol;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_scn(input int ncyc);
    int            base, tper, p_sw, nt, n, p, d;
    logic [CH-1:0] ep;
    bit            et;
    exp_t          e;
    enable      = 1'b0;
    mode        = s_mode;
    final_value = TB'(s_fv);
    top         = R'(s_top);
    polarity    = s_pol;
    for (int c = 0; c < CH; c++) duty[c*DW +: DW] = DW'(s_duty[c]);
    duty_load   = s_do_load;
    e.cyc = cyc + 1; e.pwm = s_pol; e.ptick = 1'b0;
    q.push_back(e);
    step();
    duty_load = 1'b0;
    step();
    enable = 1'b1;
    base   = cyc;
    tper   = s_fv + 1;
    p_sw   = -1;
    if (s_load_at > 0) begin
      for (int n2 = 0; n2 < 100000; n2++) begin
        if (is_end(n2, s_top, s_mode) && (tper - 1 + n2 * tper) >= s_load_at) begin
          p_sw = period_of(n2, s_top, s_mode);
          break;
        end
      end
    end
    for (int k = 0; k < ncyc; k++) begin
      nt = (k + 1) / tper;
      ep = s_pol;
      if (nt > 0) begin
        n = nt - 1;
        p = period_of(n, s_top, s_mode);
        for (int c = 0; c < CH; c++) begin
          d = (s_load_at > 0 && p > p_sw) ? s_new[c] : s_duty[c];
          ep[c] = (d > seq_cnt(n, s_top, s_mode)) ^ s_pol[c];
        end
      end
      et = ((k + 2) % tper == 0) && is_end((k + 2) / tper - 1, s_top, s_mode);
      e.cyc = base + 1 + k; e.pwm = ep; e.ptick = et;
      q.push_back(e);
    end
    for (int i = 0; i < ncyc; i++) begin
      step();
      duty_load = (s_load_at > 0) && (cyc == base + s_load_at);
      if (duty_load) begin
        for (int c = 0; c < CH; c++) duty[c*DW +: DW] = DW'(s_new[c]);
      end
    end
    duty_load = 1'b0;
    step();
  endtask

  task automatic set_all(input int d0, input int d1, input int d2, input int d3);
    s_duty[0] = d0; s_duty[1] = d1; s_duty[2] = d2; s_duty[3] = d3;
    for (int c = 0; c < CH; c++) s_new[c] = s_duty[c];
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int per, tp;
    reset_n = 1'b0; enable = 1'b0; final_value = '0; mode = 1'b0;
    top = '0; duty = '0; polarity = '0; duty_load = 1'b0;
    #1;
    checks += 2;
    if (pwm_out !== 4'b0000) begin
      errors++; $display("FAIL reset_pwm got=%b exp=0000", pwm_out);
    end
    if (period_tick !== 1'b0) begin
      errors++; $display("FAIL reset_tick got=%b exp=0", period_tick);
    end
    step(); step();
    reset_n = 1'b1;
    s_do_load = 1'b1;

    // Edge, top=9: duty 3, inverted 3, 0 and full scale.
    s_fv = 0; s_mode = 1'b0; s_top = 9; s_pol = 4'b0010; s_load_at = 0;
    set_all(3, 3, 0, 10);
    run_scn(35);

    // Prescaled edge: 8 of every 20 clocks high.
    s_fv = 3; s_mode = 1'b0; s_top = 4; s_pol = 4'b0000; s_load_at = 0;
    set_all(2, 5, 1, 4);
    run_scn(65);

    // Center, top=4.
    s_fv = 0; s_mode = 1'b1; s_top = 4; s_pol = 4'b1000; s_load_at = 0;
    set_all(2, 5, 0, 4);
    run_scn(30);

    // Shadow load mid-period, then on the period boundary.
    s_fv = 0; s_mode = 1'b0; s_top = 9; s_pol = 4'b0000;
    set_all(3, 3, 3, 3);
    s_new[0] = 7; s_new[1] = 0; s_new[2] = 10; s_new[3] = 1;
    s_load_at = 4;
    run_scn(35);
    set_all(3, 3, 3, 3);
    s_new[0] = 7; s_new[1] = 9; s_new[2] = 2; s_new[3] = 10;
    s_load_at = 19;
    run_scn(45);

    // Randomized runs.
    for (int r = 0; r < 10; r++) begin
      s_fv   = $urandom_range(0, 3);
      s_mode = $urandom_range(0, 1);
      tp     = $urandom_range(0, 12);
      s_top  = tp;
      s_pol  = CH'($urandom_range(0, 15));
      for (int c = 0; c < CH; c++) begin
        s_duty[c] = $urandom_range(0, tp + 2);
        s_new[c]  = $urandom_range(0, tp + 2);
      end
      per = (tp == 0) ? 1 : (s_mode ? 2 * tp : tp + 1);
      per = (s_fv + 1) * per * 3 + 5;
      s_load_at = ($urandom_range(0, 1) == 1) ? $urandom_range(1, per - 1) : 0;
      run_scn(per);
    end

    // Reset in the middle of a high pulse.
    s_fv = 0; s_mode = 1'b0; s_top = 9; s_pol = 4'b0000; s_load_at = 0;
    set_all(5, 5, 5, 5);
    run_scn(12);
    checks++;
    if (pwm_out !== 4'b1111) begin
      errors++; $display("FAIL pre_reset_pwm got=%b exp=1111", pwm_out);
    end
    reset_n = 1'b0;
    #1;
    checks += 2;
    if (pwm_out !== 4'b0000) begin
      errors++; $display("FAIL async_reset_pwm got=%b exp=0000", pwm_out);
    end
    if (period_tick !== 1'b0) begin
      errors++; $display("FAIL async_reset_tick got=%b exp=0", period_tick);
    end
    enable = 1'b0;
    step(); step();
    reset_n = 1'b1;

    // Without a load the reset top (255) and zero duty must be in force.
    s_do_load = 1'b0;
    s_fv = 0; s_mode = 1'b0; s_top = 255; s_pol = 4'b0000; s_load_at = 0;
    set_all(0, 0, 0, 0);
    run_scn(520);

    step(); step();
    checks++;
    if (q.size() != 0) begin
      errors++; $display("FAIL unchecked_entries got=%0d exp=0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Multi-channel PWM generator, successor to the single-channel PWM. It drives CH outputs from one shared prescaler and one shared period counter. Added over the single-channel block: a programmable period top, edge- or center-aligned counting, shadowed duty/top registers updated only at period boundaries, per-channel output polarity, and a period strobe. It sits between register-mapped control logic and the motor/LED output pins.

Parameters:
CH, 4, number of PWM channels
R, 8, period counter width; duty width is R+1 so 100% duty is reachable
TIMER_BITS, 15, prescaler width

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
enable  in  1  run (1) / idle (0)
FINAL_VALUE  in  TIMER_BITS  prescaler terminal count; tick every FINAL_VALUE+1 clocks
mode  in  1  0 = edge-aligned, 1 = center-aligned
top  in  R  period counter top value
duty  in  CH*(R+1)  flattened duty bus; channel i at [i*(R+1) +: R+1]
polarity  in  CH  per-channel inversion and idle level
duty_load  in  1  1-clk strobe: capture duty and top into the shadow registers
pwm_out  out  CH  registered PWM outputs
period_tick  out  1  1-clk pulse at each period end

Behaviour:
- Reset (asynchronous, reset_n=0):
  - prescaler=0, cnt=0, dir=up.
  - All active and shadow duty registers = 0.
  - Shadow and active top = all-ones (2^R-1).
  - pwm_out=0, period_tick=0.
- Prescaler:
  - Counts 0..FINAL_VALUE while enable=1; tick=1 in the cycle count==FINAL_VALUE, then wraps to 0.
  - FINAL_VALUE=0 gives tick every clock.
- Period counter (advances only on tick):
  - Edge mode: 0,1,..,TOP_a then back to 0.
  - Center mode: up to TOP_a, then down to 0, then up again. dir flips to down at TOP_a and to up at 0.
  - TOP_a=0: cnt stays 0 in both modes.
- Period end: period_end = tick & (edge: cnt==TOP_a | center: dir==down & cnt==1 | TOP_a==0). period_tick = period_end, combinational, exactly 1 clk wide.
- Shadow registers:
  - duty_load=1 writes duty→shadow_duty[i] and top→shadow_top.
  - At period_end, active ← shadow. If duty_load and period_end coincide, active takes the incoming bus value directly in that cycle.
  - Active registers never change mid-period while enable=1.
- Compare and output:
  - raw[i] = (duty_a[i] > cnt), compared at R+1 width.
  - On tick: pwm_out[i] ← raw[i] ^ polarity[i]. This gives one tick of latency from cnt to pin.
- Duty results, with P = TOP_a+1 (edge) or 2*TOP_a (center):
  - Edge mode: high for min(duty, TOP_a+1) of TOP_a+1 ticks.
  - Center mode: high for 2*duty-1 of 2*TOP_a ticks when 1 ≤ duty ≤ TOP_a.
  - duty=0: constant inactive level.
  - duty > TOP_a: constant active level.
- enable=0:
  - prescaler, cnt and dir held at reset values; period_tick=0.
  - pwm_out[i] = polarity[i] one clk after enable falls.
  - Active registers follow shadow every clock, so the next run starts from the latest load.
- enable rising: the counting sequence restarts from cnt=0, dir=up.
- mode: only sampled while enable=0. Changing it while running is illegal (bench assertion).
- Reset mid-period: all state returns to reset values immediately. No partial pulse after reset_n releases until the first tick.

Decomposition:
- Shared package/header pwm_pkg holds:
  - MODE_EDGE=1'b0, MODE_CENTER=1'b1
  - DIR_UP/DIR_DOWN encodings
  - a helper for the flattened duty slice width (R+1)
- Sub-module: reuse the existing timer_input (BITS=TIMER_BITS) as the prescaler, with enable tied to the module enable.
- Per-channel shadow, active, compare and output flop logic lives in a generate loop, not a separate module.

Test Plan:
- Edge, FINAL_VALUE=0, top=9, duty0=3, pol=0 → pwm_out[0] high 3 clks of every 10; period_tick every 10 clks.
- Extremes, edge, top=9: duty=0 → constant 0; duty=10 → constant 1; pol[1]=1 with duty=3 → pwm_out[1] low 3 of 10.
- Prescaler, FINAL_VALUE=3, top=4, duty=2 → high 8 clks of every 20; each level change aligned to a tick.
- Center, FINAL_VALUE=0, top=4, duty=2 → period 8 clks, high 3 clks, centered on cnt=0; duty=5 → constant 1.
- Shadow: running top=9, duty=3; pulse duty_load with duty=7 at cnt=4 → current period keeps 3; next period high 7. Load coinciding with period_end → new value applies to the immediately following period.
- Reset/enable: assert reset_n=0 mid-high pulse → pwm_out=0 asynchronously, top reverts to 255. enable=0 → pwm_out=polarity next clk; re-enable → cnt restarts at 0.
